// File: rtl/stream_split_fifo_if.sv
// Bundle of the wide input stream and the four per-lane output streams.
// The slave modport is the splitter's view; master is the surrounding environment.
interface stream_split_fifo_if #(
    parameter int W0 = 8,
    parameter int W1 = 8,
    parameter int W2 = 8,
    parameter int W3 = 8
);
    localparam int WI = W0 + W1 + W2 + W3;

    logic          s_stream_tvalid;
    logic [WI-1:0] s_stream_tdata;
    logic          s_stream_tready;

    logic          m_stream0_tenable, m_stream1_tenable, m_stream2_tenable, m_stream3_tenable;
    logic          m_stream0_tvalid,  m_stream1_tvalid,  m_stream2_tvalid,  m_stream3_tvalid;
    logic          m_stream0_tready,  m_stream1_tready,  m_stream2_tready,  m_stream3_tready;
    logic [W0-1:0] m_stream0_tdata;
    logic [W1-1:0] m_stream1_tdata;
    logic [W2-1:0] m_stream2_tdata;
    logic [W3-1:0] m_stream3_tdata;

    modport slave (
        input  s_stream_tvalid, s_stream_tdata,
        output s_stream_tready,
        input  m_stream0_tenable, m_stream1_tenable, m_stream2_tenable, m_stream3_tenable,
        output m_stream0_tvalid,  m_stream1_tvalid,  m_stream2_tvalid,  m_stream3_tvalid,
        output m_stream0_tdata,   m_stream1_tdata,   m_stream2_tdata,   m_stream3_tdata,
        input  m_stream0_tready,  m_stream1_tready,  m_stream2_tready,  m_stream3_tready
    );

    modport master (
        output s_stream_tvalid, s_stream_tdata,
        input  s_stream_tready,
        output m_stream0_tenable, m_stream1_tenable, m_stream2_tenable, m_stream3_tenable,
        input  m_stream0_tvalid,  m_stream1_tvalid,  m_stream2_tvalid,  m_stream3_tvalid,
        input  m_stream0_tdata,   m_stream1_tdata,   m_stream2_tdata,   m_stream3_tdata,
        output m_stream0_tready,  m_stream1_tready,  m_stream2_tready,  m_stream3_tready
    );
endinterface

// File: rtl/stream_split_fifo.sv
// One-to-four stream splitter: each lane of the packed input word feeds its own
// first-word-fall-through FIFO so per-lane consumers can run at independent rates.
module stream_split_fifo_lane #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_POW2 = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             rdy,
    output logic             valid,
    output logic [WIDTH-1:0] dout,
    output logic             full
);
    localparam int DEPTH = 1 << DEPTH_POW2;

    logic [WIDTH-1:0]    mem [DEPTH];
    logic [DEPTH_POW2:0] wr, rd;
    logic                empty, pop, do_push;

    // Extra pointer MSB separates full (MSBs differ) from empty (pointers equal).
    assign empty   = (wr == rd);
    assign full    = (wr[DEPTH_POW2] != rd[DEPTH_POW2]) &&
                     (wr[DEPTH_POW2-1:0] == rd[DEPTH_POW2-1:0]);
    assign valid   = !empty && !rst;
    assign pop     = valid && rdy;
    assign do_push = push && !full;
    assign dout    = mem[rd[DEPTH_POW2-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (do_push) wr <= wr + (DEPTH_POW2+1)'(1);
            if (pop)     rd <= rd + (DEPTH_POW2+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr[DEPTH_POW2-1:0]] <= din;
    end
endmodule

module stream_split_fifo #(
    parameter int STREAM0_WIDTH    = 8,
    parameter int STREAM1_WIDTH    = 8,
    parameter int STREAM2_WIDTH    = 8,
    parameter int STREAM3_WIDTH    = 8,
    parameter int FIFO_DEPTH0_POW2 = 5,
    parameter int FIFO_DEPTH1_POW2 = 5,
    parameter int FIFO_DEPTH2_POW2 = 5,
    parameter int FIFO_DEPTH3_POW2 = 5
) (
    input  logic aclk,
    input  logic reset,
    stream_split_fifo_if.slave bus
);
    localparam int O1 = STREAM0_WIDTH;
    localparam int O2 = O1 + STREAM1_WIDTH;
    localparam int O3 = O2 + STREAM2_WIDTH;
    localparam int STREAMI_WIDTH = O3 + STREAM3_WIDTH;

    logic [3:0] full, en, push;
    logic       accept;

    assign en = {bus.m_stream3_tenable, bus.m_stream2_tenable,
                 bus.m_stream1_tenable, bus.m_stream0_tenable};

    // Ready depends only on registered pointer state and enables, never on consumer tready.
    assign bus.s_stream_tready = !reset && (&(~full | ~en));
    assign accept              = bus.s_stream_tvalid && bus.s_stream_tready;
    assign push                = {4{accept}} & en;

    stream_split_fifo_lane #(.WIDTH(STREAM0_WIDTH), .DEPTH_POW2(FIFO_DEPTH0_POW2)) u_lane0 (
        .clk(aclk), .rst(reset), .push(push[0]),
        .din(bus.s_stream_tdata[O1-1:0]),
        .rdy(bus.m_stream0_tready), .valid(bus.m_stream0_tvalid),
        .dout(bus.m_stream0_tdata), .full(full[0]));

    stream_split_fifo_lane #(.WIDTH(STREAM1_WIDTH), .DEPTH_POW2(FIFO_DEPTH1_POW2)) u_lane1 (
        .clk(aclk), .rst(reset), .push(push[1]),
        .din(bus.s_stream_tdata[O2-1:O1]),
        .rdy(bus.m_stream1_tready), .valid(bus.m_stream1_tvalid),
        .dout(bus.m_stream1_tdata), .full(full[1]));

    stream_split_fifo_lane #(.WIDTH(STREAM2_WIDTH), .DEPTH_POW2(FIFO_DEPTH2_POW2)) u_lane2 (
        .clk(aclk), .rst(reset), .push(push[2]),
        .din(bus.s_stream_tdata[O3-1:O2]),
        .rdy(bus.m_stream2_tready), .valid(bus.m_stream2_tvalid),
        .dout(bus.m_stream2_tdata), .full(full[2]));

    stream_split_fifo_lane #(.WIDTH(STREAM3_WIDTH), .DEPTH_POW2(FIFO_DEPTH3_POW2)) u_lane3 (
        .clk(aclk), .rst(reset), .push(push[3]),
        .din(bus.s_stream_tdata[STREAMI_WIDTH-1:O3]),
        .rdy(bus.m_stream3_tready), .valid(bus.m_stream3_tvalid),
        .dout(bus.m_stream3_tdata), .full(full[3]));
endmodule

// File: tb/tb_stream_split_fifo.sv
// Directed and scoreboarded checks of the four-way stream splitter.
module tb_stream_split_fifo;
    logic aclk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 aclk = ~aclk;

    stream_split_fifo_if #(.W0(8), .W1(8), .W2(8), .W3(8)) sif ();

    stream_split_fifo #(
        .STREAM0_WIDTH(8), .STREAM1_WIDTH(8), .STREAM2_WIDTH(8), .STREAM3_WIDTH(8),
        .FIFO_DEPTH0_POW2(2), .FIFO_DEPTH1_POW2(2), .FIFO_DEPTH2_POW2(1), .FIFO_DEPTH3_POW2(3)
    ) dut (
        .aclk(aclk), .reset(reset), .bus(sif)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [3:0] vld();
        return {sif.m_stream3_tvalid, sif.m_stream2_tvalid, sif.m_stream1_tvalid, sif.m_stream0_tvalid};
    endfunction

    task automatic set_rdy(input logic [3:0] r);
        {sif.m_stream3_tready, sif.m_stream2_tready, sif.m_stream1_tready, sif.m_stream0_tready} = r;
    endtask

    task automatic set_en(input logic [3:0] e);
        {sif.m_stream3_tenable, sif.m_stream2_tenable, sif.m_stream1_tenable, sif.m_stream0_tenable} = e;
    endtask

    logic [7:0] q0[$], q1[$], q2[$], q3[$];

    initial begin
        int sent, cyc;
        logic [3:0] r;
        logic [31:0] w;

        reset = 1'b1;
        sif.s_stream_tvalid = 1'b1;
        sif.s_stream_tdata  = 32'hDEADBEEF;
        set_en(4'hF);
        set_rdy(4'hF);

        // T1: reset holds everything idle even with a pending word
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_rst_ready", 32'(sif.s_stream_tready), 32'h0);
            chk("t1_rst_valid", 32'(vld()), 32'h0);
        end
        reset = 1'b0;
        sif.s_stream_tvalid = 1'b0;
        #1;
        chk("t1_ready_after", 32'(sif.s_stream_tready), 32'h1);
        tick();
        chk("t1_nothing_stored", 32'(vld()), 32'h0);

        // T2: basic split
        sif.s_stream_tdata  = 32'h44332211;
        sif.s_stream_tvalid = 1'b1;
        tick();
        sif.s_stream_tvalid = 1'b0;
        chk("t2_valid", 32'(vld()), 32'hF);
        chk("t2_m0", 32'(sif.m_stream0_tdata), 32'h11);
        chk("t2_m1", 32'(sif.m_stream1_tdata), 32'h22);
        chk("t2_m2", 32'(sif.m_stream2_tdata), 32'h33);
        chk("t2_m3", 32'(sif.m_stream3_tdata), 32'h44);
        tick();
        chk("t2_one_cycle", 32'(vld()), 32'h0);

        // T3: backpressure on the depth-2 FIFO 2
        set_rdy(4'b1011);
        sif.s_stream_tvalid = 1'b1;
        sif.s_stream_tdata  = 32'h14131211;
        tick();
        chk("t3_w1_m0", 32'(sif.m_stream0_tdata), 32'h11);
        chk("t3_w1_m3", 32'(sif.m_stream3_tdata), 32'h14);
        sif.s_stream_tdata = 32'h24232221;
        chk("t3_ready_w2", 32'(sif.s_stream_tready), 32'h1);
        tick();
        sif.s_stream_tdata = 32'h34333231;
        chk("t3_ready_drop", 32'(sif.s_stream_tready), 32'h0);
        chk("t3_w2_m0", 32'(sif.m_stream0_tdata), 32'h21);
        chk("t3_w2_m1", 32'(sif.m_stream1_tdata), 32'h22);
        chk("t3_w2_m3", 32'(sif.m_stream3_tdata), 32'h24);
        chk("t3_m2_head", 32'(sif.m_stream2_tdata), 32'h13);
        tick();
        chk("t3_stall_valid", 32'(vld()), 32'b0100);
        chk("t3_stall_ready", 32'(sif.s_stream_tready), 32'h0);
        set_rdy(4'hF);
        tick();
        chk("t3_ready_after_pop", 32'(sif.s_stream_tready), 32'h1);
        chk("t3_m2_second", 32'(sif.m_stream2_tdata), 32'h23);
        tick();
        sif.s_stream_tvalid = 1'b0;
        chk("t3_w3_valid", 32'(vld()), 32'hF);
        chk("t3_w3_m0", 32'(sif.m_stream0_tdata), 32'h31);
        chk("t3_w3_m2", 32'(sif.m_stream2_tdata), 32'h33);
        tick();
        chk("t3_drained", 32'(vld()), 32'h0);

        // T4: enable masking
        set_en(4'b1101);
        sif.s_stream_tdata  = 32'hAABBCCDD;
        sif.s_stream_tvalid = 1'b1;
        tick();
        sif.s_stream_tvalid = 1'b0;
        chk("t4_valid", 32'(vld()), 32'b1101);
        chk("t4_m0", 32'(sif.m_stream0_tdata), 32'hDD);
        chk("t4_m2", 32'(sif.m_stream2_tdata), 32'hBB);
        chk("t4_m3", 32'(sif.m_stream3_tdata), 32'hAA);
        tick();
        chk("t4_drained", 32'(vld()), 32'h0);
        set_en(4'hF);
        set_rdy(4'b1101);
        sif.s_stream_tvalid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sif.s_stream_tdata = {4{8'(i)}};
            tick();
        end
        sif.s_stream_tvalid = 1'b0;
        chk("t4_full_blocks", 32'(sif.s_stream_tready), 32'h0);
        set_en(4'b1101);
        #1;
        chk("t4_full_masked", 32'(sif.s_stream_tready), 32'h1);
        sif.s_stream_tdata  = 32'h55555555;
        sif.s_stream_tvalid = 1'b1;
        tick();
        sif.s_stream_tvalid = 1'b0;
        chk("t4_m0_masked", 32'(sif.m_stream0_tdata), 32'h55);
        chk("t4_m1_head", 32'(sif.m_stream1_tdata), 32'h01);
        set_en(4'hF);
        set_rdy(4'hF);
        repeat (5) tick();
        chk("t4_all_empty", 32'(vld()), 32'h0);

        // T5: random traffic against a scoreboard across many pointer wraps
        sent = 0;
        cyc  = 0;
        while (sent < 10000 && cyc < 60000) begin
            r = 4'($urandom);
            set_rdy(r | 4'($urandom));
            w = $urandom;
            sif.s_stream_tdata  = w;
            sif.s_stream_tvalid = ($urandom_range(0, 9) < 7);
            #1;
            if (sif.m_stream0_tvalid && sif.m_stream0_tready) begin
                if (q0.size() == 0) chk("t5_m0_spurious", 32'h1, 32'h0);
                else chk("t5_m0", 32'(sif.m_stream0_tdata), 32'(q0.pop_front()));
            end
            if (sif.m_stream1_tvalid && sif.m_stream1_tready) begin
                if (q1.size() == 0) chk("t5_m1_spurious", 32'h1, 32'h0);
                else chk("t5_m1", 32'(sif.m_stream1_tdata), 32'(q1.pop_front()));
            end
            if (sif.m_stream2_tvalid && sif.m_stream2_tready) begin
                if (q2.size() == 0) chk("t5_m2_spurious", 32'h1, 32'h0);
                else chk("t5_m2", 32'(sif.m_stream2_tdata), 32'(q2.pop_front()));
            end
            if (sif.m_stream3_tvalid && sif.m_stream3_tready) begin
                if (q3.size() == 0) chk("t5_m3_spurious", 32'h1, 32'h0);
                else chk("t5_m3", 32'(sif.m_stream3_tdata), 32'(q3.pop_front()));
            end
            if (sif.s_stream_tvalid && sif.s_stream_tready) begin
                q0.push_back(w[7:0]);
                q1.push_back(w[15:8]);
                q2.push_back(w[23:16]);
                q3.push_back(w[31:24]);
                sent++;
            end
            tick();
            cyc++;
        end
        chk("t5_all_sent", 32'(sent), 32'd10000);
        sif.s_stream_tvalid = 1'b0;
        set_rdy(4'hF);
        cyc = 0;
        while ((q0.size() + q1.size() + q2.size() + q3.size()) != 0 && cyc < 100) begin
            if (sif.m_stream0_tvalid && q0.size() != 0) chk("t5_d0", 32'(sif.m_stream0_tdata), 32'(q0.pop_front()));
            if (sif.m_stream1_tvalid && q1.size() != 0) chk("t5_d1", 32'(sif.m_stream1_tdata), 32'(q1.pop_front()));
            if (sif.m_stream2_tvalid && q2.size() != 0) chk("t5_d2", 32'(sif.m_stream2_tdata), 32'(q2.pop_front()));
            if (sif.m_stream3_tvalid && q3.size() != 0) chk("t5_d3", 32'(sif.m_stream3_tdata), 32'(q3.pop_front()));
            tick();
            cyc++;
        end
        chk("t5_drain_left", 32'(q0.size() + q1.size() + q2.size() + q3.size()), 32'h0);
        chk("t5_no_extra", 32'(vld()), 32'h0);

        // T6: reset while FIFOs hold data
        set_rdy(4'h0);
        sif.s_stream_tvalid = 1'b1;
        sif.s_stream_tdata  = 32'h99887766;
        tick();
        tick();
        sif.s_stream_tvalid = 1'b0;
        chk("t6_pre_valid", 32'(vld()), 32'hF);
        reset = 1'b1;
        tick();
        chk("t6_rst_valid", 32'(vld()), 32'h0);
        reset = 1'b0;
        #1;
        chk("t6_after_valid", 32'(vld()), 32'h0);
        set_rdy(4'hF);
        sif.s_stream_tdata  = 32'h01020304;
        sif.s_stream_tvalid = 1'b1;
        tick();
        sif.s_stream_tvalid = 1'b0;
        chk("t6_valid", 32'(vld()), 32'hF);
        chk("t6_m0", 32'(sif.m_stream0_tdata), 32'h04);
        chk("t6_m1", 32'(sif.m_stream1_tdata), 32'h03);
        chk("t6_m2", 32'(sif.m_stream2_tdata), 32'h02);
        chk("t6_m3", 32'(sif.m_stream3_tdata), 32'h01);
        tick();
        chk("t6_drained", 32'(vld()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
